// File: rtl/path_mon_pkg.sv
// Shared types and helpers for the spy-path delay monitor.
// Optional calibration (PATH_MON_CALIB_EN) lives in path_delay_monitor.
package path_mon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        LAUNCH,
        WAIT,
        RECORD,
        DONE,
        ABORT
    } mon_state_e;

    // Sliced down to the counter width to form the saturated "no arrival" latency.
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    // Inclusive window; a reversed window (lo > hi) always reports outside.
    function automatic logic outside_window(input logic [31:0] avg,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
        return (avg < lo) || (avg > hi);
    endfunction

endpackage

// File: rtl/path_sync2.sv
// Two-flop synchronizer for the asynchronous spy-path output.
// Reset value is chosen so the synchronized level starts at the path's rest level.
module path_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/path_delay_monitor.sv
// Launch/capture monitor that averages NS latency samples of a spy path and alarms
// outside a golden window. Define PATH_MON_CALIB_EN to add self-calibration (calib_i).
module path_delay_monitor
    import path_mon_pkg::*;
#(
    parameter int CW         = 8,
    parameter int LOG2_NS    = 2,
    parameter int SETTLE_CYC = 16,
    parameter int TIMEOUT    = 200,
    parameter int PATH_INV   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [CW-1:0] thr_lo_i,
    input  logic [CW-1:0] thr_hi_i,
`ifdef PATH_MON_CALIB_EN
    input  logic          calib_i,
`endif
    input  logic          path_out_i,
    output logic          launch_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [CW-1:0] lat_avg_o,
    output logic          alarm_o,
    output logic          timeout_o
);

    localparam int NS = 1 << LOG2_NS;
    localparam int AW = CW + LOG2_NS;
    localparam logic REST = 1'(PATH_INV);
    localparam logic ACT  = ~REST;
    localparam logic [CW-1:0] LAT_SAT = ALL_ONES[CW-1:0];

    logic               s;
    mon_state_e         state;
    logic [CW-1:0]      cnt;
    logic [LOG2_NS-1:0] idx;
    logic [AW-1:0]      acc;
    logic [CW-1:0]      avg;
    logic [CW-1:0]      win_lo;
    logic [CW-1:0]      win_hi;
    logic               avg_bad;
    logic               accept;

    path_sync2 #(.RST_VAL(REST)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (path_out_i),
        .q     (s)
    );

    // A start coinciding with the done pulse belongs to the finished burst and is dropped.
    assign accept  = (state == IDLE) && start_i && !done_o;
    assign avg     = acc[AW-1:LOG2_NS];
    assign avg_bad = outside_window(32'(avg), 32'(win_lo), 32'(win_hi));

`ifdef PATH_MON_CALIB_EN
    logic          calib_q;
    logic          g_valid;
    logic [CW-1:0] g;

    always_comb begin
        win_lo = thr_lo_i;
        win_hi = thr_hi_i;
        if (g_valid) begin
            win_lo = (g == '0) ? '0 : g - CW'(1);
            win_hi = (g == LAT_SAT) ? LAT_SAT : g + CW'(1);
        end
    end

    // Golden value only updates on a calibration burst that completes normally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            calib_q <= 1'b0;
            g_valid <= 1'b0;
            g       <= '0;
        end else begin
            if (accept)
                calib_q <= calib_i;
            if (state == DONE && calib_q) begin
                g       <= avg;
                g_valid <= 1'b1;
            end
        end
    end
`else
    assign win_lo = thr_lo_i;
    assign win_hi = thr_hi_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            acc       <= '0;
            launch_o  <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            lat_avg_o <= '0;
            alarm_o   <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc       <= '0;
                        idx       <= '0;
                        cnt       <= '0;
                        alarm_o   <= 1'b0;
                        timeout_o <= 1'b0;
                        busy_o    <= 1'b1;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt >= CW'(SETTLE_CYC - 1) && s == REST)
                        state <= LAUNCH;
                    else if (cnt == CW'(TIMEOUT))
                        state <= ABORT;
                    else
                        cnt <= cnt + CW'(1);
                end
                LAUNCH: begin
                    launch_o <= 1'b1;
                    cnt      <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // cnt freezes on arrival and is consumed as the sample latency.
                    if (s == ACT)
                        state <= RECORD;
                    else if (cnt == CW'(TIMEOUT))
                        state <= ABORT;
                    else
                        cnt <= cnt + CW'(1);
                end
                RECORD: begin
                    acc      <= acc + AW'(cnt);
                    launch_o <= 1'b0;
                    if (idx == LOG2_NS'(NS - 1)) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + LOG2_NS'(1);
                        cnt   <= '0;
                        state <= SETTLE;
                    end
                end
                DONE: begin
                    lat_avg_o <= avg;
`ifdef PATH_MON_CALIB_EN
                    alarm_o   <= calib_q ? 1'b0 : avg_bad;
`else
                    alarm_o   <= avg_bad;
`endif
                    done_o    <= 1'b1;
                    busy_o    <= 1'b0;
                    state     <= IDLE;
                end
                ABORT: begin
                    timeout_o <= 1'b1;
                    alarm_o   <= 1'b1;
                    lat_avg_o <= LAT_SAT;
                    launch_o  <= 1'b0;
                    done_o    <= 1'b1;
                    busy_o    <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_path_delay_monitor.sv
// Self-checking bench for path_delay_monitor: a delay-line spy path model plus a
// burst-level expectation model; PATH_MON_CALIB_EN adds calibration bursts.
module tb_path_delay_monitor;

    localparam int   CW   = 8;
    localparam logic PINV = 1'b1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [CW-1:0] thr_lo_i;
    logic [CW-1:0] thr_hi_i;
    logic          calib_i;
    logic          path_out_i;
    logic          launch_o;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] lat_avg_o;
    logic          alarm_o;
    logic          timeout_o;

    int checks = 0;
    int errors = 0;

    // Expected burst result packed as {timeout, alarm, avg}.
    logic [CW+1:0] exp_q[$];

    // Spy path model: launch delayed by cur_dly cycles, inverted.
    logic [15:0] hist = '0;
    int          dly_tab[4];
    int          samp = 0;
    int          base = 0;
    int          cur_dly;
    bit          stuck = 1'b0;
    logic        launch_q = 1'b0;

    // Golden value tracked by the model when calibration is enabled.
    int g = 0;
    bit g_valid = 1'b0;

    always #5 clk = ~clk;

    path_delay_monitor #(
        .CW(CW), .LOG2_NS(2), .SETTLE_CYC(16), .TIMEOUT(200), .PATH_INV(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .thr_lo_i   (thr_lo_i),
        .thr_hi_i   (thr_hi_i),
`ifdef PATH_MON_CALIB_EN
        .calib_i    (calib_i),
`endif
        .path_out_i (path_out_i),
        .launch_o   (launch_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .lat_avg_o  (lat_avg_o),
        .alarm_o    (alarm_o),
        .timeout_o  (timeout_o)
    );

    always @(posedge clk) hist <= {hist[14:0], launch_o};

    // Counts launch falling edges so each sample of a burst can use its own delay.
    always @(negedge clk) begin
        if (launch_q && !launch_o) samp = samp + 1;
        launch_q = launch_o;
    end

    always_comb begin
        int k;
        k = samp - base;
        if (k > 3) k = 3;
        if (k < 0) k = 0;
        cur_dly = dly_tab[k];
    end

    always_comb begin
        if (stuck)
            path_out_i = PINV;
        else if (cur_dly == 0)
            path_out_i = PINV ^ launch_o;
        else
            path_out_i = PINV ^ hist[cur_dly-1];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Burst result from the rules: each latency is delay+2, average truncates,
    // timeout saturates, calibration redefines the window as g-1..g+1.
    task automatic push_expect(input int d0, input int d1, input int d2, input int d3,
                               input int lo, input int hi, input bit stk, input bit cal);
        int avg;
        int wlo;
        int whi;
        bit al;
        if (stk) begin
            exp_q.push_back({1'b1, 1'b1, 8'd255});
        end else begin
            avg = ((d0 + 2) + (d1 + 2) + (d2 + 2) + (d3 + 2)) / 4;
            wlo = lo;
            whi = hi;
            if (g_valid) begin
                wlo = (g == 0) ? 0 : g - 1;
                whi = (g == 255) ? 255 : g + 1;
            end
            al = cal ? 1'b0 : ((avg < wlo) || (avg > whi));
            exp_q.push_back({1'b0, al, 8'(avg)});
            if (cal) begin
                g = avg;
                g_valid = 1'b1;
            end
        end
    endtask

    task automatic start_pulse(input bit cal);
        @(negedge clk);
        base    = samp;
        start_i = 1'b1;
        calib_i = cal;
        @(negedge clk);
        start_i = 1'b0;
        calib_i = 1'b0;
    endtask

    task automatic run_burst(input int d0, input int d1, input int d2, input int d3,
                             input int lo, input int hi, input bit stk, input bit cal,
                             input int lit_avg, input bit lit_alarm);
        bit seen;
        dly_tab[0] = d0; dly_tab[1] = d1; dly_tab[2] = d2; dly_tab[3] = d3;
        stuck    = stk;
        thr_lo_i = 8'(lo);
        thr_hi_i = 8'(hi);
        push_expect(d0, d1, d2, d3, lo, hi, stk, cal);
        start_pulse(cal);
        check("busy_after_start", 32'(busy_o), 32'd1);
        // A start while busy must not disturb the burst.
        repeat (30) @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: got no done_o expected done_o within 3000 cycles");
            void'(exp_q.pop_front());
        end else begin
            check("avg_literal", 32'(lat_avg_o), 32'(lit_avg));
            check("alarm_literal", 32'(alarm_o), 32'(lit_alarm));
            // Start coinciding with done_o is ignored.
            start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
            check("done_one_cycle", 32'(done_o), 32'd0);
            check("busy_after_done", 32'(busy_o), 32'd0);
            check("launch_after_done", 32'(launch_o), 32'd0);
        end
        stuck = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_launch"}, 32'(launch_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_avg"}, 32'(lat_avg_o), 32'd0);
        check({tag, "_alarm"}, 32'(alarm_o), 32'd0);
        check({tag, "_timeout"}, 32'(timeout_o), 32'd0);
    endtask

    initial begin
        bit reached;
        rst_n    = 1'b0;
        start_i  = 1'b0;
        calib_i  = 1'b0;
        thr_lo_i = '0;
        thr_hi_i = '0;
        for (int i = 0; i < 4; i++) dly_tab[i] = 5;

        // Compare process: every done_o pulse is checked against the model.
        fork
            forever begin
                logic [CW+1:0] e;
                @(negedge clk);
                if (rst_n && done_o) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done_o=1 expected no burst pending");
                    end else begin
                        e = exp_q.pop_front();
                        check("model_avg", 32'(lat_avg_o), 32'(e[CW-1:0]));
                        check("model_alarm", 32'(alarm_o), 32'(e[CW]));
                        check("model_timeout", 32'(timeout_o), 32'(e[CW+1]));
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_burst(5, 5, 5, 5, 6, 8, 1'b0, 1'b0, 7, 1'b0);
        run_burst(9, 9, 9, 9, 6, 8, 1'b0, 1'b0, 11, 1'b1);
        check("trojan_no_timeout", 32'(timeout_o), 32'd0);
        run_burst(5, 5, 5, 5, 6, 8, 1'b1, 1'b0, 255, 1'b1);
        check("stuck_timeout", 32'(timeout_o), 32'd1);
        run_burst(4, 5, 5, 6, 6, 8, 1'b0, 1'b0, 7, 1'b0);
        run_burst(4, 4, 4, 5, 6, 8, 1'b0, 1'b0, 6, 1'b0);
        run_burst(6, 6, 6, 6, 6, 8, 1'b0, 1'b0, 8, 1'b0);
        run_burst(3, 3, 3, 3, 6, 8, 1'b0, 1'b0, 5, 1'b1);
        run_burst(5, 5, 5, 5, 9, 3, 1'b0, 1'b0, 7, 1'b1);

        // Reset during WAIT of the second sample: no done, everything cleared.
        for (int i = 0; i < 4; i++) dly_tab[i] = 5;
        thr_lo_i = 8'd6;
        thr_hi_i = 8'd8;
        start_pulse(1'b0);
        reached = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if ((samp - base) == 1 && launch_o) begin
                reached = 1'b1;
                break;
            end
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL second_launch_timeout: got no second launch expected one within 500 cycles");
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (3) @(negedge clk);
        check("midreset_no_done", 32'(done_o), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_burst(5, 5, 5, 5, 6, 8, 1'b0, 1'b0, 7, 1'b0);

`ifdef PATH_MON_CALIB_EN
        run_burst(5, 5, 5, 5, 0, 0, 1'b0, 1'b1, 7, 1'b0);
        run_burst(7, 7, 7, 7, 0, 255, 1'b0, 1'b0, 9, 1'b1);
        run_burst(6, 6, 6, 6, 0, 255, 1'b0, 1'b0, 8, 1'b0);
        run_burst(3, 3, 3, 3, 0, 255, 1'b0, 1'b0, 5, 1'b1);
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
